// File: rtl/ram_access_arbiter.sv
// Single owner of the 64 KB image RAM port: boot loader fill first, then CPU (fixed priority) and diag reader with a starvation guard.
// Latency: request seen in IDLE -> ram_cs for ACCESS_CYCLES cycles -> one-cycle ack; requesters hold their level request until ack.
module ram_access_arbiter #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = 2,
    parameter int MAX_DEFER     = 8
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              load_complete,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_hold,
    input  logic              dg_req,
    input  logic [ADDR_W-1:0] dg_addr,
    output logic [DATA_W-1:0] dg_rdata,
    output logic              dg_ack,
    output logic              ld_late,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_datain,
    input  logic [DATA_W-1:0] ram_dataout,
    output logic              ram_cs,
    output logic              ram_we
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK} state_t;
    typedef enum logic [1:0] {W_NONE, W_LD, W_CPU, W_DG} who_t;

    state_t            r_state;
    state_t            w_next_state;
    who_t              r_who;
    who_t              w_win;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    logic [3:0]        r_count;
    logic [7:0]        r_defer;
    logic              r_sync1;
    logic              r_sync2;
    logic              r_done;
    logic              r_ld_late;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dg_rdata;
    logic              w_load_done;
    logic              w_dg_force;

    // Synchroniser output counts immediately so the CPU is released two clocks after load_complete.
    assign w_load_done = r_sync2 | r_done;
    assign w_dg_force  = dg_req && (r_defer >= 8'(MAX_DEFER));

    always_comb begin
        w_win        = W_NONE;
        w_next_state = r_state;
        if (!w_load_done) begin
            if (ld_req) w_win = W_LD;
        end else if (w_dg_force) begin
            w_win = W_DG;
        end else if (cpu_req) begin
            w_win = W_CPU;
        end else if (dg_req) begin
            w_win = W_DG;
        end
        case (r_state)
            S_IDLE:   if (w_win != W_NONE) w_next_state = S_ACCESS;
            S_ACCESS: if (r_count == 4'd0) w_next_state = S_ACK;
            S_ACK:    w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state     <= S_IDLE;
            r_who       <= W_NONE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_count     <= 4'd0;
            r_defer     <= 8'd0;
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_done      <= 1'b0;
            r_ld_late   <= 1'b0;
            r_cpu_rdata <= '0;
            r_dg_rdata  <= '0;
        end else begin
            r_sync1 <= load_complete;
            r_sync2 <= r_sync1;
            r_done  <= w_load_done;
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (w_win != W_NONE) begin
                        r_who   <= w_win;
                        r_count <= 4'(ACCESS_CYCLES - 1);
                    end
                    case (w_win)
                        W_LD: begin
                            r_addr  <= ld_addr;
                            r_wdata <= ld_wdata;
                            r_we    <= 1'b1;
                        end
                        W_CPU: begin
                            r_addr  <= cpu_addr;
                            r_wdata <= cpu_wdata;
                            r_we    <= cpu_we;
                        end
                        W_DG: begin
                            r_addr <= dg_addr;
                            r_we   <= 1'b0;
                        end
                        default: ;
                    endcase
                    // Before the fill completes the defer counter is frozen.
                    if (w_load_done) begin
                        if (ld_req) r_ld_late <= 1'b1;
                        if (!dg_req || w_win == W_DG) r_defer <= 8'd0;
                        else if (r_defer != 8'hFF)    r_defer <= r_defer + 8'd1;
                    end
                end
                S_ACCESS: begin
                    if (r_count != 4'd0) begin
                        r_count <= r_count - 4'd1;
                    end else if (!r_we) begin
                        if (r_who == W_CPU) r_cpu_rdata <= ram_dataout;
                        if (r_who == W_DG)  r_dg_rdata  <= ram_dataout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ram_cs      = (r_state == S_ACCESS);
    assign ram_we      = (r_state == S_ACCESS) && r_we;
    assign ram_address = r_addr;
    assign ram_datain  = r_wdata;
    assign ld_ack      = (r_state == S_ACK) && (r_who == W_LD);
    assign cpu_ack     = (r_state == S_ACK) && (r_who == W_CPU);
    assign dg_ack      = (r_state == S_ACK) && (r_who == W_DG);
    assign cpu_rdata   = r_cpu_rdata;
    assign dg_rdata    = r_dg_rdata;
    assign cpu_hold    = !w_load_done;
    assign ld_late     = r_ld_late;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Bench for ram_access_arbiter: directed table/sequences plus randomized traffic against a transaction-level model.
module tb_ram_access_arbiter;
    localparam int AC = 2;
    localparam int MD = 8;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        load_complete = 1'b0;
    logic        ld_req = 1'b0;
    logic [15:0] ld_addr = 16'h0;
    logic [7:0]  ld_wdata = 8'h0;
    logic        ld_ack;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0;
    logic [7:0]  cpu_wdata = 8'h0;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack, cpu_hold;
    logic        dg_req = 1'b0;
    logic [15:0] dg_addr = 16'h0;
    logic [7:0]  dg_rdata;
    logic        dg_ack, ld_late;
    logic [15:0] ram_address;
    logic [7:0]  ram_datain, ram_dataout;
    logic        ram_cs, ram_we;

    // Second instance with single-cycle access, used for the wrap-free corner case.
    logic        load_complete2 = 1'b1;
    logic        ld_req2 = 1'b0;
    logic [15:0] ld_addr2 = 16'h0;
    logic [7:0]  ld_wdata2 = 8'h0;
    logic        ld_ack2;
    logic        cpu_req2 = 1'b0;
    logic        cpu_we2 = 1'b0;
    logic [15:0] cpu_addr2 = 16'h0;
    logic [7:0]  cpu_wdata2 = 8'h0;
    logic [7:0]  cpu_rdata2;
    logic        cpu_ack2, cpu_hold2;
    logic        dg_req2 = 1'b0;
    logic [15:0] dg_addr2 = 16'h0;
    logic [7:0]  dg_rdata2;
    logic        dg_ack2, ld_late2;
    logic [15:0] ram_address2;
    logic [7:0]  ram_datain2, ram_dataout2;
    logic        ram_cs2, ram_we2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_access_arbiter #(.ADDR_W(16), .DATA_W(8), .ACCESS_CYCLES(AC), .MAX_DEFER(MD)) dut (
        .clk(clk), .rst_l(rst_l), .load_complete(load_complete),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_hold(cpu_hold),
        .dg_req(dg_req), .dg_addr(dg_addr), .dg_rdata(dg_rdata), .dg_ack(dg_ack),
        .ld_late(ld_late), .ram_address(ram_address), .ram_datain(ram_datain),
        .ram_dataout(ram_dataout), .ram_cs(ram_cs), .ram_we(ram_we));

    ram_access_arbiter #(.ADDR_W(16), .DATA_W(8), .ACCESS_CYCLES(1), .MAX_DEFER(MD)) dut2 (
        .clk(clk), .rst_l(rst_l), .load_complete(load_complete2),
        .ld_req(ld_req2), .ld_addr(ld_addr2), .ld_wdata(ld_wdata2), .ld_ack(ld_ack2),
        .cpu_req(cpu_req2), .cpu_we(cpu_we2), .cpu_addr(cpu_addr2), .cpu_wdata(cpu_wdata2),
        .cpu_rdata(cpu_rdata2), .cpu_ack(cpu_ack2), .cpu_hold(cpu_hold2),
        .dg_req(dg_req2), .dg_addr(dg_addr2), .dg_rdata(dg_rdata2), .dg_ack(dg_ack2),
        .ld_late(ld_late2), .ram_address(ram_address2), .ram_datain(ram_datain2),
        .ram_dataout(ram_dataout2), .ram_cs(ram_cs2), .ram_we(ram_we2));

    function automatic logic [7:0] init_f(input logic [15:0] a);
        return a[15:8] ^ a[7:0] ^ 8'h7A;
    endfunction

    // RAM primitive: unwritten locations return init_f(address).
    bit [7:0] mem [0:65535];
    bit       wr_flag [0:65535];
    always @(posedge clk) begin
        if (ram_cs && ram_we) begin
            mem[ram_address]     <= ram_datain;
            wr_flag[ram_address] <= 1'b1;
        end
    end
    assign ram_dataout  = wr_flag[ram_address] ? mem[ram_address] : init_f(ram_address);
    assign ram_dataout2 = init_f(ram_address2);

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_access(input logic we, input logic [15:0] a, input logic [7:0] d, output int lat);
        cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!cpu_ack && lat < 40);
        cpu_req = 1'b0;
    endtask

    typedef struct {
        logic        ld;
        logic        cpu;
        logic [4:0]  exp_ctl;   // {ram_cs, ram_we, ld_ack, cpu_ack, cpu_hold}
    } vec_t;

    vec_t vecs [5];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        int lat, n, guard, seen, k, t;
        logic grant [18];
        int ack_t [4];
        // random-phase model state
        int cyc, m_idle, m_def, pend_who, ack_cyc, win, idx;
        logic pend_we, late_exp, exp_c, exp_d;
        logic [7:0] exp_rd;
        logic [7:0] mmem [16];

        vecs[0] = '{1'b1, 1'b1, 5'b11001};
        vecs[1] = '{1'b1, 1'b1, 5'b11001};
        vecs[2] = '{1'b1, 1'b1, 5'b00101};
        vecs[3] = '{1'b0, 1'b1, 5'b00001};
        vecs[4] = '{1'b0, 1'b1, 5'b00001};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            64'({ram_cs, ram_we, ld_ack, cpu_ack, dg_ack, cpu_hold, ld_late, cpu_rdata, dg_rdata, ram_address, ram_datain}),
            64'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 16'h0000, 8'h00}));
        rst_l = 1'b1;
        tick();

        // Loader fill while the CPU is held
        ld_addr = 16'h0000; ld_wdata = 8'hA5;
        for (int i = 0; i < 5; i++) begin
            ld_req = vecs[i].ld; cpu_req = vecs[i].cpu;
            tick();
            chk($sformatf("load_vec%0d", i), 64'({ram_cs, ram_we, ld_ack, cpu_ack, cpu_hold, ram_address, ram_datain}),
                64'({vecs[i].exp_ctl, 16'h0000, 8'hA5}));
        end
        cpu_req = 1'b0;

        // load_complete synchronisation, then CPU read
        load_complete = 1'b1;
        tick();
        chk("hold_after_1clk", 64'(cpu_hold), 64'(1'b1));
        tick();
        chk("hold_after_2clk", 64'(cpu_hold), 64'(1'b0));
        cpu_access(1'b0, 16'h1234, 8'h00, lat);
        chk("cpu_read_latency", 64'(lat), 64'(AC + 1));
        chk("cpu_read_data", 64'(cpu_rdata), 64'(8'h5C));

        // Late loader request
        ld_req = 1'b1; ld_addr = 16'h0005; seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ld_ack) seen++;
        end
        ld_req = 1'b0;
        chk("late_ld_no_ack", 64'(seen), 64'(0));
        chk("ld_late_set", 64'(ld_late), 64'(1'b1));

        // Starvation guard: CPU x8, diag, CPU x8, diag
        cpu_we = 1'b0; cpu_addr = 16'h1234; dg_addr = 16'h0000;
        cpu_req = 1'b1; dg_req = 1'b1;
        n = 0; guard = 0;
        while (n < 18 && guard < 300) begin
            tick();
            guard++;
            if (cpu_ack) begin
                grant[n] = 1'b0; n++;
                chk("grant_cpu_rdata", 64'(cpu_rdata), 64'(8'h5C));
            end else if (dg_ack) begin
                grant[n] = 1'b1; n++;
                chk("grant_dg_rdata", 64'(dg_rdata), 64'(8'hA5));
            end
        end
        cpu_req = 1'b0; dg_req = 1'b0;
        chk("grant_count", 64'(n), 64'(18));
        for (int i = 0; i < n; i++)
            chk($sformatf("grant_seq%0d", i), 64'(grant[i]), 64'(i == 8 || i == 17));

        // Back-to-back CPU writes
        cpu_we = 1'b1; cpu_addr = 16'h2000; cpu_wdata = 8'h11; cpu_req = 1'b1;
        k = 0; t = 0;
        while (k < 4 && t < 100) begin
            tick();
            t++;
            if (cpu_ack) begin
                ack_t[k] = t; k++;
                cpu_addr = 16'h2000 + 16'(k);
                cpu_wdata = 8'(8'h11 * (k + 1));
            end
        end
        cpu_req = 1'b0;
        chk("b2b_count", 64'(k), 64'(4));
        for (int i = 1; i < k; i++)
            chk($sformatf("b2b_spacing%0d", i), 64'(ack_t[i] - ack_t[i-1]), 64'(AC + 2));
        chk("write_keeps_rdata", 64'(cpu_rdata), 64'(8'h5C));
        chk("write_reached_ram", 64'({mem[16'h2000], mem[16'h2003]}), 64'({8'h11, 8'h44}));

        // Reset during a CPU write access
        tick();
        cpu_we = 1'b1; cpu_addr = 16'h3000; cpu_wdata = 8'h77; cpu_req = 1'b1;
        guard = 0;
        while (!ram_cs && guard < 10) begin
            tick();
            guard++;
        end
        chk("rst_access_started", 64'({ram_cs, ram_we}), 64'(2'b11));
        #2 rst_l = 1'b0;
        #1;
        chk("rst_mid_access", 64'({ram_cs, ram_we, ld_ack, cpu_ack, dg_ack, cpu_hold, ld_late}), 64'(7'b0000010));
        cpu_req = 1'b0;
        tick();
        rst_l = 1'b1;
        tick();
        chk("rst_resync_1clk", 64'({cpu_hold, cpu_ack}), 64'(2'b10));
        tick();
        chk("rst_resync_2clk", 64'({cpu_hold, cpu_ack}), 64'(2'b00));

        // Randomized traffic against a transaction-level model
        for (int i = 0; i < 16; i++) mmem[i] = init_f(16'h0100 + 16'(i));
        cyc = 0; m_idle = 1; m_def = 0; pend_who = 0; ack_cyc = 0;
        pend_we = 1'b0; late_exp = 1'b0; exp_rd = 8'h00;
        for (int it = 0; it < 900; it++) begin
            tick();
            cyc++;
            exp_c = (pend_who == 1) && (cyc == ack_cyc);
            exp_d = (pend_who == 2) && (cyc == ack_cyc);
            chk("rnd_acks", 64'({ld_ack, cpu_ack, dg_ack}), 64'({1'b0, exp_c, exp_d}));
            if (exp_c && !pend_we) chk("rnd_cpu_rdata", 64'(cpu_rdata), 64'(exp_rd));
            if (exp_d)             chk("rnd_dg_rdata", 64'(dg_rdata), 64'(exp_rd));
            if (exp_c || exp_d) pend_who = 0;
            if (cpu_ack || !cpu_req) begin
                cpu_req   = ($urandom_range(0, 3) != 0);
                cpu_we    = $urandom_range(0, 1) == 1;
                cpu_addr  = 16'h0100 + 16'($urandom_range(0, 15));
                cpu_wdata = 8'($urandom);
            end
            if (dg_ack || !dg_req) begin
                dg_req  = ($urandom_range(0, 2) != 0);
                dg_addr = 16'h0100 + 16'($urandom_range(0, 15));
            end
            ld_req = ($urandom_range(0, 15) == 0);
            if (cyc == m_idle) begin
                if (ld_req) late_exp = 1'b1;
                win = 0;
                if (dg_req && m_def >= MD) win = 2;
                else if (cpu_req)          win = 1;
                else if (dg_req)           win = 2;
                if (!dg_req || win == 2) m_def = 0;
                else if (m_def < 255)    m_def = m_def + 1;
                if (win != 0) begin
                    pend_who = win;
                    ack_cyc  = cyc + AC + 1;
                    m_idle   = cyc + AC + 2;
                    if (win == 1) begin
                        idx = int'(cpu_addr - 16'h0100);
                        pend_we = cpu_we;
                        if (cpu_we) mmem[idx] = cpu_wdata;
                        exp_rd = mmem[idx];
                    end else begin
                        idx = int'(dg_addr - 16'h0100);
                        pend_we = 1'b0;
                        exp_rd = mmem[idx];
                    end
                end else begin
                    m_idle = cyc + 1;
                end
            end
        end
        cpu_req = 1'b0; dg_req = 1'b0; ld_req = 1'b0;
        chk("rnd_ld_late", 64'(ld_late), 64'(late_exp));
        repeat (6) tick();

        // Single-cycle access diag read at the top of the address space
        dg_addr2 = 16'hFFFF; dg_req2 = 1'b1;
        tick();
        chk("top_access", 64'({ram_cs2, ram_we2, dg_ack2, ram_address2}), 64'({3'b100, 16'hFFFF}));
        tick();
        chk("top_ack", 64'({ram_cs2, dg_ack2, dg_rdata2, ram_address2}), 64'({2'b01, 8'h7A, 16'hFFFF}));
        dg_req2 = 1'b0;
        tick();
        chk("top_idle", 64'({ram_cs2, dg_ack2, ram_address2}), 64'({2'b00, 16'hFFFF}));
        chk("top_other_outputs",
            64'({ld_ack2, cpu_ack2, cpu_hold2, ld_late2, ram_we2, ram_datain2, cpu_rdata2}),
            64'({5'b00000, 8'h00, 8'h00}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Single owner of the shared 64 KB ROM/RAM image port.
- Sequences the boot-time flash-to-RAM fill (loader requester) and holds the CPU off until the fill completes.
- After the fill, shares the port between the CPU bus and the diagnostic dump reader. CPU has fixed priority; a starvation guard protects the diagnostic reader.
- Sits between the SPI flash loader, the CPU bus interface, the diagnostic reader and the RAM primitive.

Parameters:
ADDR_W, 16, RAM address width
DATA_W, 8, RAM data width
ACCESS_CYCLES, 2, cycles ram_cs is held per access (legal 1..15)
MAX_DEFER, 8, consecutive denied cycles of a pending diag request before diag is forced ahead of CPU (legal 1..255)

Ports:
clk  in  1  system clock
rst_l  in  1  asynchronous active-low reset
load_complete  in  1  level from flash loader; same-clock-domain-unsafe, synchronised internally
ld_req  in  1  loader write request (level)
ld_addr  in  ADDR_W  loader write address
ld_wdata  in  DATA_W  loader write data
ld_ack  out  1  one-cycle pulse: loader write done
cpu_req  in  1  CPU access request (level)
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  CPU read data, valid when cpu_ack is high
cpu_ack  out  1  one-cycle pulse: CPU access done
cpu_hold  out  1  1 = hold CPU (RDY low / reset) until load is done
dg_req  in  1  diagnostic read request (level)
dg_addr  in  ADDR_W  diagnostic read address
dg_rdata  out  DATA_W  diagnostic read data, valid when dg_ack is high
dg_ack  out  1  one-cycle pulse: diagnostic read done
ld_late  out  1  sticky: loader requested after load_done
ram_address  out  ADDR_W  RAM address
ram_datain  out  DATA_W  RAM write data
ram_dataout  in  DATA_W  RAM read data, combinational from ram_address
ram_cs  out  1  RAM select
ram_we  out  1  RAM write enable

Behaviour:
- Reset (async on rst_l low, takes effect immediately, mid-access included):
  - all outputs 0 except cpu_hold = 1.
  - FSM to IDLE; defer counter 0; synchroniser flops 0; load_done 0; ld_late 0.
  - An in-flight access is abandoned with no ack.
- load_done: load_complete passes through a 2-flop synchroniser and is then sticky (set only, cleared only by reset). cpu_hold = !load_done.
- Requests are levels sampled in IDLE. A requester holds req/addr/data stable until its ack. If req is still high in the cycle after ack, that is a new request.
- FSM states:
  - IDLE: pick a winner; latch winner id, address, write data and we. Go to ACCESS with count = ACCESS_CYCLES-1. No winner: stay in IDLE.
  - ACCESS: ram_cs = 1; ram_address and ram_datain come from the latched values; ram_we = latched we for every ACCESS cycle. Decrement count. When count = 0, capture ram_dataout into the winner's rdata register (reads only) and go to ACK.
  - ACK: ram_cs = 0, ram_we = 0. Pulse the winner's ack for exactly this cycle. Go to IDLE.
- Latency: request seen in IDLE at cycle N gives ram_cs high in cycles N+1..N+ACCESS_CYCLES and ack in cycle N+ACCESS_CYCLES+1. Minimum spacing between accesses is ACCESS_CYCLES+2 cycles.
- Arbitration while load_done = 0:
  - Only ld_req is eligible; loader writes are always writes.
  - cpu_req and dg_req are ignored, with no ack and the defer counter held.
- Arbitration while load_done = 1, priority highest to lowest:
  1. dg, if defer counter >= MAX_DEFER
  2. cpu
  3. dg
  - ld_req is never granted; ld_req high in IDLE sets ld_late.
- Defer counter:
  - Increments, saturating at 255, on each IDLE cycle where dg_req = 1 and dg loses.
  - Clears when dg wins, or when dg_req = 0 in IDLE.
- load_complete rising mid-loader-access: the access completes and acks normally; the new arbitration rules apply from the next IDLE.
- rdata registers hold their last value until the next read completes for that requester. Writes never change rdata.
- Address and data are passed through unmodified; there is no wrap logic. The requester owns address increment and wrap at 16'hFFFF.

Test Plan:
1. Reset, load_complete = 0, ld_req with ld_addr = 16'h0000, ld_wdata = 8'hA5, ACCESS_CYCLES = 2 -> ram_cs/ram_we high for 2 cycles with address 0 and data A5, ld_ack one cycle later; cpu_hold = 1 throughout; concurrent cpu_req gets no cpu_ack.
2. Raise load_complete -> cpu_hold falls exactly 2 clocks later. CPU read of 16'h1234 with RAM returning 8'h5C -> cpu_rdata = 5C while cpu_ack is high. A later ld_req sets ld_late = 1 and never gets ld_ack.
3. After load, cpu_req and dg_req held continuously, MAX_DEFER = 8 -> CPU wins each IDLE until the defer count reaches 8, then one dg access, then CPU again. Check the exact grant sequence and that dg never waits more than 8 IDLE losses.
4. Back-to-back CPU writes with cpu_req held high -> a new access every ACCESS_CYCLES+2 cycles. A write leaves cpu_rdata unchanged.
5. Assert rst_l low during ACCESS of a CPU write -> ram_cs, ram_we and all acks drop immediately; cpu_hold = 1; after release, load_done = 0 until load_complete is re-synchronised.
6. ACCESS_CYCLES = 1 with a dg read at 16'hFFFF -> ram_cs high for 1 cycle, dg_ack in the next cycle, and ram_address stays at 16'hFFFF (no wrap).
